cpu_control_fsm: RTL and testbench
==================================

Name: cpu_control_fsm

Overview:
Multi-cycle sequencer for the CPU core. It steps each instruction through fetch, decode, execute, memory and writeback. It pulses the instruction decoder's enable, handshakes with the instruction and data memory ports, and issues register-file and PC write strobes. A wait-state timeout drives the core into a sticky fault state.

Parameters:
MEM_TIMEOUT, 255, maximum cycles a memory request may wait for its ready before the block enters FAULT.
TIMEOUT_W, 8, width of the wait counter; must satisfy 2**TIMEOUT_W > MEM_TIMEOUT.

Ports:
clk  in  1  core clock; all state changes on posedge.
reset  in  1  asynchronous, active-high; returns the block to IDLE.
run  in  1  level; fetch is allowed while high.
ifetch_req  out  1  instruction fetch request, held until ifetch_ready.
ifetch_ready  in  1  instruction word valid this cycle.
ir_load  out  1  latch instruction register.
instr_class  in  3  IR[27:25].
decode_enable  out  1  one-cycle decoder enable.
dec_valid  in  1  decoder valid.
dec_opcode  in  4  decoder opcode.
dec_mem_read  in  1  decoder mem_read.
dec_mem_write  in  1  decoder mem_write.
dec_is_not_postindex  in  1  decoder P bit.
dec_is_write_back  in  1  decoder W bit.
dec_branch_with_link  in  1  decoder L bit for branches.
cond_pass  in  1  condition-code check result.
alu_enable  out  1  ALU / address-generation strobe.
dmem_req  out  1  data memory request.
dmem_we  out  1  1 = store, 0 = load.
dmem_ready  in  1  data access complete.
reg_write  out  1  Rd write strobe.
reg_write_sel  out  2  00 ALU result, 01 load data, 10 PC+4 (link to R14).
base_write  out  1  Rn base writeback strobe.
pc_write  out  1  PC update strobe.
pc_sel  out  1  0 = PC+4, 1 = branch target.
instr_retired  out  1  one-cycle pulse per completed instruction.
fault  out  1  sticky error flag.
state_dbg  out  3  current state.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6. State is registered. Outputs are combinational from state plus inputs.
- Reset (asynchronous, any state, including mid-handshake): state goes to IDLE and the wait counter clears. The fault flag, and every output except state_dbg=0, reads 0 during and after reset.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH:
  - ifetch_req=1.
  - On ifetch_ready=1: ir_load=1 the same cycle, then go to DECODE.
  - Wait counter increments each cycle without ready. When the count reaches MEM_TIMEOUT, go to FAULT.
- DECODE: decode_enable=1 for exactly one cycle, then go to EXECUTE. Decoder outputs are valid in EXECUTE.
- EXECUTE:
  - dec_valid=0, or dec_mem_read and dec_mem_write both 1 → FAULT.
  - cond_pass=0 → WRITEBACK with all architectural writes suppressed.
  - Otherwise alu_enable=1, then:
    - dec_mem_read or dec_mem_write → MEMORY.
    - Any other instruction → WRITEBACK.
- MEMORY:
  - dmem_req=1 and dmem_we=dec_mem_write, held until dmem_ready.
  - On dmem_ready → WRITEBACK.
  - Timeout → FAULT, using the same rule as FETCH.
  - The wait counter clears on every state entry.
- WRITEBACK (exactly one cycle):
  - pc_write=1 and instr_retired=1.
  - pc_sel=1 only when instr_class=101 and cond_pass=1.
  - reg_write=1 when cond_pass=1 and any of the following holds:
    - Data processing (class 000/001) with dec_opcode outside 1000–1011, reg_write_sel=00.
    - Load (class 010/011 with dec_mem_read), reg_write_sel=01.
    - Branch-with-link, reg_write_sel=10.
  - base_write=1 when cond_pass=1, class 010/011, and (dec_is_write_back or !dec_is_not_postindex).
  - Next state is FETCH if run=1, else IDLE.
- run dropping mid-instruction does not abort; the instruction completes, then the block parks in IDLE.
- FAULT: fault=1, all strobes 0, stays in FAULT until reset. Classes 100/110/111 also go to FAULT from EXECUTE.
- Minimum latency: 4 cycles per non-memory instruction, 5 per memory instruction (zero-wait ready). Back-to-back throughput: one retire per 4 or 5 cycles.

Decomposition:
- Shared header cpu_ctrl_defs.vh holds:
  - the state encodings;
  - the instruction class codes 000/001/010/011/101, shared with the decoder;
  - the reg_write_sel codes;
  - the compare-opcode range 1000–1011.
- One sub-module, wait_timer: loadable up-counter with clear, enable and expired output, parameterised by MEM_TIMEOUT and TIMEOUT_W.

Test Plan:
- ADD (class 000, opcode 0100, cond_pass=1), ifetch_ready asserted in the first FETCH cycle → state sequence 1,2,3,5; reg_write=1 with sel=00; pc_write=1 with pc_sel=0; retire pulse at cycle 4.
- LDR with W=1 and dmem_ready after 3 wait cycles → dmem_req high for 4 cycles with dmem_we=0; then reg_write sel=01, base_write=1 and retire in WRITEBACK.
- BL (class 101, L=1) with cond_pass=1 → pc_sel=1, reg_write=1 with sel=10. Repeat with cond_pass=0 → pc_sel=0, reg_write=0, pc_write=1.
- CMP (opcode 1010) → reg_write=0. STR with P=1, W=0 → dmem_we=1, base_write=0.
- MEM_TIMEOUT=4 with ifetch_ready held low → FAULT after 4 FETCH cycles; fault stays 1 for 20 more cycles; async reset mid-cycle → fault=0 and state 0 immediately.
- run deasserted during MEMORY → the instruction retires, then state goes to IDLE with no further ifetch_req; run reasserted → FETCH the next cycle.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the CPU control sequencer: state encodings,
// instruction class codes, register write-select codes and the
// compare-opcode range shared with the instruction decoder.
package cpu_control_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  localparam logic [2:0] CLASS_DP_REG = 3'b000;
  localparam logic [2:0] CLASS_DP_IMM = 3'b001;
  localparam logic [2:0] CLASS_LS_IMM = 3'b010;
  localparam logic [2:0] CLASS_LS_REG = 3'b011;
  localparam logic [2:0] CLASS_BRANCH = 3'b101;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  localparam logic [3:0] CMP_OP_LO = 4'b1000;
  localparam logic [3:0] CMP_OP_HI = 4'b1011;

  function automatic logic is_data_proc(input logic [2:0] cls);
    return (cls == CLASS_DP_REG) || (cls == CLASS_DP_IMM);
  endfunction

  function automatic logic is_load_store(input logic [2:0] cls);
    return (cls == CLASS_LS_IMM) || (cls == CLASS_LS_REG);
  endfunction

  // Compare/test opcodes set flags only and never write Rd
  function automatic logic is_compare_op(input logic [3:0] op);
    return (op >= CMP_OP_LO) && (op <= CMP_OP_HI);
  endfunction

  // Classes this sequencer knows how to step; anything else faults
  function automatic logic is_known_class(input logic [2:0] cls);
    return is_data_proc(cls) || is_load_store(cls) || (cls == CLASS_BRANCH);
  endfunction

endpackage

// File: rtl/cpu_control_fsm_wait_timer.sv
// Wait-state counter for memory handshakes. Counts cycles spent waiting
// for a ready; expired flags the cycle that would be the last allowed one.
module wait_timer #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 load,
  input  logic [TIMEOUT_W-1:0] load_value,
  output logic                 expired
);

  // Expired while count equals MEM_TIMEOUT-1: if ready is still absent in
  // this cycle, the count reaches MEM_TIMEOUT on the coming edge.
  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(MEM_TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count;

  // Clear wins over load, load wins over counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory and
// writeback, with a wait-state timeout that parks the core in FAULT.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TIMEOUT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic       ifetch_req,
  input  logic       ifetch_ready,
  output logic       ir_load,
  input  logic [2:0] instr_class,
  output logic       decode_enable,
  input  logic       dec_valid,
  input  logic [3:0] dec_opcode,
  input  logic       dec_mem_read,
  input  logic       dec_mem_write,
  input  logic       dec_is_not_postindex,
  input  logic       dec_is_write_back,
  input  logic       dec_branch_with_link,
  input  logic       cond_pass,
  output logic       alu_enable,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ready,
  output logic       reg_write,
  output logic [1:0] reg_write_sel,
  output logic       base_write,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       instr_retired,
  output logic       fault,
  output logic [2:0] state_dbg
);

  state_t state, next_state;
  logic   wait_clear, wait_enable, wait_expired;

  // The wait count restarts on every state entry and only advances while
  // a request is outstanding without its ready.
  assign wait_clear  = (next_state != state);
  assign wait_enable = ((state == ST_FETCH)  && !ifetch_ready) ||
                       ((state == ST_MEMORY) && !dmem_ready);

  wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TIMEOUT_W  (TIMEOUT_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (wait_clear),
    .enable    (wait_enable),
    .load      (1'b0),
    .load_value('0),
    .expired   (wait_expired)
  );

  // State register; reset parks the sequencer in IDLE from any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and strobe decode from current state plus handshake inputs
  always_comb begin
    next_state    = state;
    ifetch_req    = 1'b0;
    ir_load       = 1'b0;
    decode_enable = 1'b0;
    alu_enable    = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    reg_write     = 1'b0;
    reg_write_sel = SEL_ALU;
    base_write    = 1'b0;
    pc_write      = 1'b0;
    pc_sel        = 1'b0;
    instr_retired = 1'b0;
    fault         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        ifetch_req = 1'b1;
        if (ifetch_ready) begin
          ir_load    = 1'b1;
          next_state = ST_DECODE;
        end else if (wait_expired) begin
          next_state = ST_FAULT;
        end
      end
      ST_DECODE: begin
        decode_enable = 1'b1;
        next_state    = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (!dec_valid || (dec_mem_read && dec_mem_write) || !is_known_class(instr_class)) begin
          next_state = ST_FAULT;
        end else if (!cond_pass) begin
          next_state = ST_WRITEBACK;
        end else begin
          alu_enable = 1'b1;
          next_state = (dec_mem_read || dec_mem_write) ? ST_MEMORY : ST_WRITEBACK;
        end
      end
      ST_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ready)        next_state = ST_WRITEBACK;
        else if (wait_expired) next_state = ST_FAULT;
      end
      ST_WRITEBACK: begin
        pc_write      = 1'b1;
        instr_retired = 1'b1;
        pc_sel        = (instr_class == CLASS_BRANCH) && cond_pass;
        if (cond_pass) begin
          if (is_data_proc(instr_class) && !is_compare_op(dec_opcode)) begin
            reg_write     = 1'b1;
            reg_write_sel = SEL_ALU;
          end else if (is_load_store(instr_class) && dec_mem_read) begin
            reg_write     = 1'b1;
            reg_write_sel = SEL_LOAD;
          end else if ((instr_class == CLASS_BRANCH) && dec_branch_with_link) begin
            reg_write     = 1'b1;
            reg_write_sel = SEL_LINK;
          end
          base_write = is_load_store(instr_class) &&
                       (dec_is_write_back || !dec_is_not_postindex);
        end
        next_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed testbench for cpu_control_fsm with a short memory timeout.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       ifetch_req, ifetch_ready, ir_load;
  logic [2:0] instr_class;
  logic       decode_enable, dec_valid;
  logic [3:0] dec_opcode;
  logic       dec_mem_read, dec_mem_write, dec_is_not_postindex, dec_is_write_back;
  logic       dec_branch_with_link, cond_pass;
  logic       alu_enable, dmem_req, dmem_we, dmem_ready;
  logic       reg_write;
  logic [1:0] reg_write_sel;
  logic       base_write, pc_write, pc_sel, instr_retired, fault;
  logic [2:0] state_dbg;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_v;

  cpu_control_fsm #(.MEM_TIMEOUT(4), .TIMEOUT_W(3)) dut (
    .clk(clk), .reset(reset), .run(run),
    .ifetch_req(ifetch_req), .ifetch_ready(ifetch_ready), .ir_load(ir_load),
    .instr_class(instr_class), .decode_enable(decode_enable),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode),
    .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_is_not_postindex(dec_is_not_postindex), .dec_is_write_back(dec_is_write_back),
    .dec_branch_with_link(dec_branch_with_link), .cond_pass(cond_pass),
    .alu_enable(alu_enable), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ready(dmem_ready), .reg_write(reg_write), .reg_write_sel(reg_write_sel),
    .base_write(base_write), .pc_write(pc_write), .pc_sel(pc_sel),
    .instr_retired(instr_retired), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Observed vector: {state, ifetch_req, ir_load, decode_enable, alu_enable,
  // dmem_req, dmem_we, reg_write, reg_write_sel, base_write, pc_write,
  // pc_sel, instr_retired, fault}
  function automatic logic [16:0] obs();
    return {state_dbg, ifetch_req, ir_load, decode_enable, alu_enable, dmem_req, dmem_we,
            reg_write, reg_write_sel, base_write, pc_write, pc_sel, instr_retired, fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [2:0] cls, input logic [3:0] op, input logic valid,
                           input logic rd, input logic wr, input logic p, input logic w,
                           input logic l, input logic cp);
    instr_class = cls; dec_opcode = op; dec_valid = valid;
    dec_mem_read = rd; dec_mem_write = wr; dec_is_not_postindex = p;
    dec_is_write_back = w; dec_branch_with_link = l; cond_pass = cp;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; ifetch_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; ifetch_ready = 1'b1; dmem_ready = 1'b1;
    set_instr(3'b000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    exp_v = {3'd0, 7'b0000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL reset_initial got=%b exp=%b", obs(), exp_v); end
    tick();
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL reset_held got=%b exp=%b", obs(), exp_v); end
    @(negedge clk);
    reset = 1'b0; run = 1'b0; ifetch_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL reset_release got=%b exp=%b", obs(), exp_v); end
  endtask

  task automatic test_add();
    set_instr(3'b000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run = 1'b1; ifetch_ready = 1'b1;
    #1;
    exp_v = {3'd0, 7'b0000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL add_idle got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd1, 7'b1100000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL add_fetch got=%b exp=%b", obs(), exp_v); end
    tick(); ifetch_ready = 1'b0; #1;
    exp_v = {3'd2, 7'b0010000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL add_decode got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd3, 7'b0001000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL add_execute got=%b exp=%b", obs(), exp_v); end
    tick(); run = 1'b0; #1;
    exp_v = {3'd5, 7'b0000001, 2'b00, 5'b01010};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL add_writeback got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd0, 7'b0000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL add_park got=%b exp=%b", obs(), exp_v); end
  endtask

  task automatic test_load_wait();
    set_instr(3'b010, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run = 1'b1; ifetch_ready = 1'b1;
    tick();
    exp_v = {3'd1, 7'b1100000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL ldr_fetch got=%b exp=%b", obs(), exp_v); end
    tick(); ifetch_ready = 1'b0; #1;
    tick();
    exp_v = {3'd3, 7'b0001000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL ldr_execute got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd4, 7'b0000100, 2'b00, 5'b00000};
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL ldr_wait%0d got=%b exp=%b", i, obs(), exp_v); end
      tick();
    end
    dmem_ready = 1'b1; #1;
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL ldr_ready got=%b exp=%b", obs(), exp_v); end
    tick(); dmem_ready = 1'b0; run = 1'b0; #1;
    exp_v = {3'd5, 7'b0000001, 2'b01, 5'b11010};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL ldr_writeback got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd0, 7'b0000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL ldr_park got=%b exp=%b", obs(), exp_v); end
  endtask

  task automatic test_back_to_back();
    set_instr(3'b101, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run = 1'b1; ifetch_ready = 1'b1;
    tick();
    tick(); ifetch_ready = 1'b0; #1;
    tick();
    exp_v = {3'd3, 7'b0001000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL bl_execute got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd5, 7'b0000001, 2'b10, 5'b01110};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL bl_writeback got=%b exp=%b", obs(), exp_v); end
    cond_pass = 1'b0; ifetch_ready = 1'b1;
    tick();
    exp_v = {3'd1, 7'b1100000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL b2b_fetch got=%b exp=%b", obs(), exp_v); end
    tick(); ifetch_ready = 1'b0; #1;
    exp_v = {3'd2, 7'b0010000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL b2b_decode got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd3, 7'b0000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL blnc_execute got=%b exp=%b", obs(), exp_v); end
    tick(); run = 1'b0; #1;
    exp_v = {3'd5, 7'b0000000, 2'b00, 5'b01010};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL blnc_writeback got=%b exp=%b", obs(), exp_v); end
    tick();
  endtask

  task automatic test_compare();
    set_instr(3'b000, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run = 1'b1; ifetch_ready = 1'b1;
    tick();
    tick(); ifetch_ready = 1'b0; #1;
    tick();
    tick(); run = 1'b0; #1;
    exp_v = {3'd5, 7'b0000000, 2'b00, 5'b01010};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL cmp_writeback got=%b exp=%b", obs(), exp_v); end
    tick();
  endtask

  task automatic test_store_run_drop();
    set_instr(3'b011, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run = 1'b1; ifetch_ready = 1'b1;
    tick();
    tick(); ifetch_ready = 1'b0; #1;
    tick();
    exp_v = {3'd3, 7'b0001000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL str_execute got=%b exp=%b", obs(), exp_v); end
    tick(); run = 1'b0; dmem_ready = 1'b1; #1;
    exp_v = {3'd4, 7'b0000110, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL str_memory got=%b exp=%b", obs(), exp_v); end
    tick(); dmem_ready = 1'b0; #1;
    exp_v = {3'd5, 7'b0000000, 2'b00, 5'b01010};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL str_writeback got=%b exp=%b", obs(), exp_v); end
    exp_v = {3'd0, 7'b0000000, 2'b00, 5'b00000};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL str_parked%0d got=%b exp=%b", i, obs(), exp_v); end
    end
    run = 1'b1; #1;
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL str_rerun_idle got=%b exp=%b", obs(), exp_v); end
    tick();
    exp_v = {3'd1, 7'b1000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL str_rerun_fetch got=%b exp=%b", obs(), exp_v); end
    do_reset();
  endtask

  task automatic test_exec_fault();
    logic [2:0] cls_tab [3] = '{3'b110, 3'b000, 3'b010};
    logic       val_tab [3] = '{1'b1, 1'b0, 1'b1};
    logic       rw_tab  [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      set_instr(cls_tab[k], 4'b0100, val_tab[k], rw_tab[k], rw_tab[k], 1'b1, 1'b0, 1'b0, 1'b1);
      run = 1'b1; ifetch_ready = 1'b1;
      tick();
      tick(); ifetch_ready = 1'b0; #1;
      tick();
      exp_v = {3'd3, 7'b0000000, 2'b00, 5'b00000};
      checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL xfault%0d_execute got=%b exp=%b", k, obs(), exp_v); end
      tick();
      exp_v = {3'd6, 7'b0000000, 2'b00, 5'b00001};
      checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL xfault%0d_fault got=%b exp=%b", k, obs(), exp_v); end
    end
    do_reset();
  endtask

  task automatic test_timeout();
    set_instr(3'b000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run = 1'b1; ifetch_ready = 1'b0;
    tick();
    exp_v = {3'd1, 7'b1000000, 2'b00, 5'b00000};
    for (int i = 0; i < 4; i++) begin
      checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL tmo_fetch%0d got=%b exp=%b", i, obs(), exp_v); end
      tick();
    end
    exp_v = {3'd6, 7'b0000000, 2'b00, 5'b00001};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL tmo_fault got=%b exp=%b", obs(), exp_v); end
    ifetch_ready = 1'b1; dmem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL tmo_sticky%0d got=%b exp=%b", i, obs(), exp_v); end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_v = {3'd0, 7'b0000000, 2'b00, 5'b00000};
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL tmo_async_reset got=%b exp=%b", obs(), exp_v); end
    tick();
    checks++; if (obs() !== exp_v) begin failures++; $display("[TB] FAIL tmo_reset_held got=%b exp=%b", obs(), exp_v); end
    run = 1'b0; ifetch_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_back_to_back();
    test_compare();
    test_store_run_drop();
    test_exec_fault();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
